instr_decode_regfile: RTL and testbench
=======================================

Name: instr_decode_regfile

Overview:
- Decode stage of the 32-bit pipelined core.
- Splits the fetched instruction into fields and generates one-hot-ish control selects for execute, memory, kernel-cache and branch units.
- Holds the 16x32 general register file: reads operands, accepts write-back from the WB stage.
- Sits between fetch (instruction, PCi) and execute (OPA, OPB, STR_DATA, PCo, RKo, RDo, FUNTYPE, FUNCODE, sel*).

Parameters:
- bus, 32, datapath width of register file, operands, PC and write-back data.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- instruction  in  32  fetched instruction
- WBd  in  bus  write-back data
- PCi  in  bus  PC of current instruction
- RDwb  in  4  write-back destination register
- WE  in  1  write-back enable
- CPSR  in  4  flags {N,Z,C,V} = bits [3:0]
- OPA  out  bus  operand A
- OPB  out  bus  operand B
- STR_DATA  out  bus  store data
- PCo  out  bus  next-PC / branch target
- RKo  out  bus  kernel operand
- RDo  out  4  destination register index
- FUNTYPE  out  2  instruction class
- FUNCODE  out  2  operation within class
- selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH  out  1 each  control selects

Behaviour:
- One clock domain; reset is synchronous and active-low (rst_n sampled on rising clk).
- Field map:
  - FUNTYPE = instr[31:30]
  - FUNCODE = instr[29:28]
  - RD = instr[27:24]
  - RA = instr[23:20]
  - RB = instr[19:16]
  - imm15 = instr[15:1]
  - I = instr[0] (immediate flag)
- All decode outputs are purely combinational from instruction, PCi, CPSR and register contents. Zero latency; valid without any clock edge.
- Register file:
  - 16 x bus registers.
  - On rising clk: if rst_n=0, all registers are cleared to 0.
  - Else if WE=1, R[RDwb] <= WBd.
  - Reads are asynchronous.
- Operands:
  - OPA = R[RA]; for FUNTYPE=10 (branches), OPA = PCi (link value).
  - OPB = I ? zero-extended imm15 : R[RB].
  - STR_DATA = R[RD]; RKo = R[RB]; RDo = RD.
- Branch target:
  - T = PCi + sign-extended imm15.
  - B (10_00): PCo = T.
  - BEQ (10_01): PCo = T if CPSR[2]=1, else PCo = PCi.
  - All other instructions: PCo = PCi.
- Control truth table (selects not listed are 0):
  - 00_00 ADD: selWB=1
  - 00_01 SUB: selWB=1
  - 00_10 MOV: selWB=1
  - 00_11 CMP: all selects 0
  - 01_00 LDR: selWB=1, selMEMRD=1
  - 01_01 STR: selMEMWR=1
  - 01_10, 01_11 reserved: all selects 0
  - 10_00 B: selWB=1, selBRANCH=1
  - 10_01 BEQ: selWB=1, selBRANCH=1, independent of CPSR
  - 10_10, 10_11 reserved: all selects 0
  - 11_00 KRN: selWB=1
  - 11_01 LKN: selCACHEWR=1
  - 11_10 LDK: selWB=1
  - 11_11 SHK: selCACHESH=1
- FUNTYPE/FUNCODE outputs always equal instr[31:28], including reserved codes.
- Reset effect on outputs: after reset, all register reads return 0. With instruction=0 and PCi=0, all bus outputs and RDo are 0, selWB=1 (ADD), other selects 0.
- Simultaneous reset and WE=1: reset wins.
- Writing R0 is permitted; R0 is an ordinary register, not hardwired to zero.

Optional Feature:
- RF_BYPASS_EN defined: when WE=1 and RDwb equals a read index (RA, RB or RD), that read returns WBd combinationally in the same cycle (write-through forwarding). rst_n=0 suppresses the bypass.
- RF_BYPASS_EN undefined: reads return stored contents only; a write is visible from the cycle after the clock edge.

Test Plan:
- Reset (rst_n=0, one clk), then instruction=32'h0 -> OPA=OPB=STR_DATA=RKo=0, FUNTYPE=00, FUNCODE=00, selWB=1, other selects 0.
- Write R8 with WE=1, RDwb=8, WBd=3, one clk; then ADD with RA=8, RB=2, I=0 -> OPA=3, OPB=R2. Same with I=1, imm15=5 -> OPB=5.
- Sweep all 16 FUNTYPE/FUNCODE codes with other bits fixed -> selects exactly match the truth table, e.g.:
  - CMP: all 0
  - LDR: selWB=1, selMEMRD=1
  - STR: selMEMWR=1
  - LKN: selCACHEWR=1
  - SHK: selCACHESH=1
  - reserved codes: all 0
- B with PCi=12, imm15=8 -> PCo=20, selBRANCH=1, OPA=12. BEQ with CPSR=0 -> PCo=12, selBRANCH=1. BEQ with CPSR=4'b0100 -> PCo=20.
- Negative offset: B with PCi=12, imm15=15'h7FFC -> PCo=8.
- Write R1=7 and read R1 in the same cycle -> OPA=7 with RF_BYPASS_EN, old value without; after the clk edge, 7 in both builds.

Source files
------------

// File: rtl/instr_decode_regfile.sv
// Decode stage: instruction field split, control selects, 16 x bus register file.
// Define RF_BYPASS_EN to forward same-cycle write-back data onto the read ports.
module instr_decode_regfile #(
    parameter int bus = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [31:0]    instruction,
    input  logic [bus-1:0] WBd,
    input  logic [bus-1:0] PCi,
    input  logic [3:0]     RDwb,
    input  logic           WE,
    input  logic [3:0]     CPSR,
    output logic [bus-1:0] OPA,
    output logic [bus-1:0] OPB,
    output logic [bus-1:0] STR_DATA,
    output logic [bus-1:0] PCo,
    output logic [bus-1:0] RKo,
    output logic [3:0]     RDo,
    output logic [1:0]     FUNTYPE,
    output logic [1:0]     FUNCODE,
    output logic           selWB,
    output logic           selMEMRD,
    output logic           selMEMWR,
    output logic           selCACHEWR,
    output logic           selCACHESH,
    output logic           selBRANCH
);

    logic [1:0]     funtype;
    logic [1:0]     funcode;
    logic [3:0]     rd;
    logic [3:0]     ra;
    logic [3:0]     rb;
    logic [14:0]    imm15;
    logic           imm_flag;
    logic [bus-1:0] regs [16];
    logic [bus-1:0] rd_a;
    logic [bus-1:0] rd_b;
    logic [bus-1:0] rd_d;
    logic [bus-1:0] imm_zext;
    logic [bus-1:0] imm_sext;
    logic [bus-1:0] target;
    logic           is_branch;

    assign funtype   = instruction[31:30];
    assign funcode   = instruction[29:28];
    assign rd        = instruction[27:24];
    assign ra        = instruction[23:20];
    assign rb        = instruction[19:16];
    assign imm15     = instruction[15:1];
    assign imm_flag  = instruction[0];

    assign imm_zext  = {{(bus-15){1'b0}}, imm15};
    assign imm_sext  = {{(bus-15){imm15[14]}}, imm15};
    assign target    = PCi + imm_sext;
    assign is_branch = (funtype == 2'b10);

    assign FUNTYPE   = funtype;
    assign FUNCODE   = funcode;
    assign RDo       = rd;
    assign STR_DATA  = rd_d;
    assign RKo       = rd_b;

    // Register file write port: synchronous clear has priority over write-back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (WE) begin
            regs[RDwb] <= WBd;
        end
    end

    // Asynchronous read ports, optionally forwarding the pending write-back.
    always_comb begin
        rd_a = regs[ra];
        rd_b = regs[rb];
        rd_d = regs[rd];
`ifdef RF_BYPASS_EN
        if (rst_n && WE) begin
            if (RDwb == ra) rd_a = WBd;
            if (RDwb == rb) rd_b = WBd;
            if (RDwb == rd) rd_d = WBd;
        end
`else
`endif
    end

    // Operand muxing and next-PC selection.
    always_comb begin
        OPA = is_branch ? PCi : rd_a;
        OPB = imm_flag ? imm_zext : rd_b;
        PCo = PCi;
        if (is_branch) begin
            if (funcode == 2'b00) begin
                PCo = target;
            end else if (funcode == 2'b01 && CPSR[2]) begin
                PCo = target;
            end
        end
    end

    // Control select decode from the 4-bit class/operation code.
    always_comb begin
        selWB      = 1'b0;
        selMEMRD   = 1'b0;
        selMEMWR   = 1'b0;
        selCACHEWR = 1'b0;
        selCACHESH = 1'b0;
        selBRANCH  = 1'b0;
        case ({funtype, funcode})
            4'b0000,
            4'b0001,
            4'b0010: selWB = 1'b1;
            4'b0100: begin
                selWB    = 1'b1;
                selMEMRD = 1'b1;
            end
            4'b0101: selMEMWR = 1'b1;
            4'b1000,
            4'b1001: begin
                selWB     = 1'b1;
                selBRANCH = 1'b1;
            end
            4'b1100: selWB = 1'b1;
            4'b1101: selCACHEWR = 1'b1;
            4'b1110: selWB = 1'b1;
            4'b1111: selCACHESH = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_decode_regfile.sv
// Self-checking bench for instr_decode_regfile: directed vectors,
// a select truth-table sweep and randomized traffic against a reference model.
module tb_instr_decode_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic [31:0] wbd;
    logic [31:0] pci;
    logic [3:0]  rdwb;
    logic        we;
    logic [3:0]  cpsr;
    logic [31:0] opa, opb, str_data, pco, rko;
    logic [3:0]  rdo;
    logic [1:0]  funtype, funcode;
    logic        sel_wb, sel_memrd, sel_memwr, sel_cachewr, sel_cachesh, sel_branch;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] mem [16];

    instr_decode_regfile #(.bus(32)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .WBd(wbd),
        .PCi(pci), .RDwb(rdwb), .WE(we), .CPSR(cpsr),
        .OPA(opa), .OPB(opb), .STR_DATA(str_data), .PCo(pco), .RKo(rko),
        .RDo(rdo), .FUNTYPE(funtype), .FUNCODE(funcode),
        .selWB(sel_wb), .selMEMRD(sel_memrd), .selMEMWR(sel_memwr),
        .selCACHEWR(sel_cachewr), .selCACHESH(sel_cachesh),
        .selBRANCH(sel_branch)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int ft, input int fc, input int d,
                                       input int a, input int b, input int imm,
                                       input int i);
        logic [31:0] w;
        w = ((ft & 3) << 30) | ((fc & 3) << 28) | ((d & 15) << 24)
          | ((a & 15) << 20) | ((b & 15) << 16) | ((imm & 32'h7fff) << 1)
          | (i & 1);
        return w;
    endfunction

    // selects packed as {WB, MEMRD, MEMWR, CACHEWR, CACHESH, BRANCH}
    function automatic logic [5:0] sel_of(input logic [3:0] code);
        case (code)
            4'h0, 4'h1, 4'h2: return 6'b100000;
            4'h4:             return 6'b110000;
            4'h5:             return 6'b001000;
            4'h8, 4'h9:       return 6'b100001;
            4'hC, 4'hE:       return 6'b100000;
            4'hD:             return 6'b000100;
            4'hF:             return 6'b000010;
            default:          return 6'b000000;
        endcase
    endfunction

    function automatic logic [31:0] rdm(input logic [3:0] idx);
`ifdef RF_BYPASS_EN
        if (rst_n && we && rdwb == idx) return wbd;
`endif
        return mem[idx];
    endfunction

    function automatic logic [5:0] dut_sel();
        return {sel_wb, sel_memrd, sel_memwr, sel_cachewr, sel_cachesh, sel_branch};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full output check against the behavioural model.
    task automatic check_model(input string tag);
        int ft, fc, off, imm;
        logic [31:0] e_opa, e_opb, e_pc;
        ft  = int'(instruction[31:30]);
        fc  = int'(instruction[29:28]);
        imm = int'(instruction[15:1]);
        off = (imm >= 16384) ? imm - 32768 : imm;
        e_opa = (ft == 2) ? pci : rdm(instruction[23:20]);
        e_opb = instruction[0] ? 32'(imm) : rdm(instruction[19:16]);
        e_pc  = pci;
        if (ft == 2 && (fc == 0 || (fc == 1 && cpsr[2])))
            e_pc = pci + 32'(off);
        cmp({tag, ".OPA"}, opa, e_opa);
        cmp({tag, ".OPB"}, opb, e_opb);
        cmp({tag, ".STR"}, str_data, rdm(instruction[27:24]));
        cmp({tag, ".RKo"}, rko, rdm(instruction[19:16]));
        cmp({tag, ".PCo"}, pco, e_pc);
        cmp({tag, ".RDo"}, 32'(rdo), 32'(instruction[27:24]));
        cmp({tag, ".FT"}, 32'(funtype), 32'(ft));
        cmp({tag, ".FC"}, 32'(funcode), 32'(fc));
        cmp({tag, ".SEL"}, 32'(dut_sel()), 32'(sel_of(instruction[31:28])));
    endtask

    // One clock: commit write-back to the model, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] = '0;
        end else if (we) begin
            mem[rdwb] = wbd;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] code;
        logic [5:0] sel;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{4'h0, 6'b100000};
        vecs[1]  = '{4'h1, 6'b100000};
        vecs[2]  = '{4'h2, 6'b100000};
        vecs[3]  = '{4'h3, 6'b000000};
        vecs[4]  = '{4'h4, 6'b110000};
        vecs[5]  = '{4'h5, 6'b001000};
        vecs[6]  = '{4'h6, 6'b000000};
        vecs[7]  = '{4'h7, 6'b000000};
        vecs[8]  = '{4'h8, 6'b100001};
        vecs[9]  = '{4'h9, 6'b100001};
        vecs[10] = '{4'hA, 6'b000000};
        vecs[11] = '{4'hB, 6'b000000};
        vecs[12] = '{4'hC, 6'b100000};
        vecs[13] = '{4'hD, 6'b000100};
        vecs[14] = '{4'hE, 6'b100000};
        vecs[15] = '{4'hF, 6'b000010};
        for (int i = 0; i < 16; i++) mem[i] = '0;

        rst_n = 1'b0; we = 1'b0; rdwb = '0; wbd = '0;
        instruction = '0; pci = '0; cpsr = '0;
        tick();
        rst_n = 1'b1;
        #1;
        cmp("rst.OPA", opa, 0);
        cmp("rst.OPB", opb, 0);
        cmp("rst.STR", str_data, 0);
        cmp("rst.RKo", rko, 0);
        cmp("rst.PCo", pco, 0);
        cmp("rst.RDo", 32'(rdo), 0);
        cmp("rst.SEL", 32'(dut_sel()), 32'b100000);

        // R8 = 3, then ADD reads it
        we = 1'b1; rdwb = 4'd8; wbd = 32'd3;
        tick();
        we = 1'b0;
        instruction = mk(0, 0, 1, 8, 2, 0, 0);
        #1;
        cmp("add.OPA", opa, 3);
        cmp("add.OPB", opb, 0);
        instruction = mk(0, 0, 1, 8, 2, 5, 1);
        #1;
        cmp("addi.OPB", opb, 5);
        check_model("addi");

        // select sweep
        for (int i = 0; i < 16; i++) begin
            instruction = {vecs[i].code, 28'h345_0000};
            #1;
            cmp($sformatf("sweep%0d.SEL", i), 32'(dut_sel()), 32'(vecs[i].sel));
            cmp($sformatf("sweep%0d.CODE", i), 32'({funtype, funcode}), 32'(vecs[i].code));
        end

        // branches
        pci = 32'd12; cpsr = 4'b0000;
        instruction = mk(2, 0, 0, 3, 0, 8, 0);
        #1;
        cmp("b.PCo", pco, 20);
        cmp("b.OPA", opa, 12);
        cmp("b.BR", 32'(sel_branch), 1);
        instruction = mk(2, 1, 0, 3, 0, 8, 0);
        #1;
        cmp("beq0.PCo", pco, 12);
        cmp("beq0.BR", 32'(sel_branch), 1);
        cpsr = 4'b0100;
        #1;
        cmp("beq1.PCo", pco, 20);
        instruction = mk(2, 0, 0, 0, 0, 32'h7ffc, 0);
        #1;
        cmp("bneg.PCo", pco, 8);
        instruction = mk(0, 0, 0, 0, 0, 32'h7ffc, 0);
        #1;
        cmp("addneg.PCo", pco, 12);

        // same-cycle write and read of R1
        instruction = mk(0, 0, 0, 1, 0, 0, 0);
        we = 1'b1; rdwb = 4'd1; wbd = 32'd7;
        #1;
`ifdef RF_BYPASS_EN
        cmp("byp.OPA", opa, 7);
`else
        cmp("byp.OPA", opa, 0);
`endif
        tick();
        we = 1'b0;
        #1;
        cmp("byp_after.OPA", opa, 7);

        // R0 is an ordinary register
        we = 1'b1; rdwb = 4'd0; wbd = 32'hdead_beef;
        tick();
        we = 1'b0;
        instruction = mk(0, 0, 0, 0, 0, 0, 0);
        #1;
        cmp("r0.OPA", opa, 32'hdead_beef);

        // reset beats simultaneous write
        rst_n = 1'b0; we = 1'b1; rdwb = 4'd0; wbd = 32'h1234_5678;
        #1;
        cmp("rstwe.OPA", opa, 32'hdead_beef);
        tick();
        rst_n = 1'b1; we = 1'b0;
        instruction = mk(0, 0, 1, 0, 8, 0, 0);
        #1;
        cmp("rstwe.R0", opa, 0);
        cmp("rstwe.R8", opb, 0);
        cmp("rstwe.R1", str_data, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            we = $urandom_range(0, 1) == 1;
            rdwb = 4'($urandom);
            wbd = $urandom;
            instruction = $urandom;
            pci = $urandom;
            cpsr = 4'($urandom);
            #1;
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
